cacheline_burst_adaptor: RTL and testbench

Memory-side end of the cache line interface. Accepts a 256-bit line read (fill) or write (writeback) from the cache datapath/control on the line port. Services it on main memory as a 4-beat, 64-bit burst. Returns the assembled line and a one-cycle completion pulse. Sits between the cache and the physical memory or arbiter.

---
 rtl/cacheline_burst_adaptor_pkg.sv | 23 ++
 rtl/cacheline_burst_adaptor_burst_shift_reg.sv | 34 +++
 rtl/cacheline_burst_adaptor.sv | 128 ++++++++++++
 tb/tb_cacheline_burst_adaptor.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/cacheline_burst_adaptor_pkg.sv
// Shared types for the cache line / memory burst adaptor.
package cache_adaptor_types;

  localparam int unsigned BEATS  = 4;
  localparam int unsigned BEAT_W = 64;
  localparam int unsigned LINE_W = BEATS * BEAT_W;

  typedef logic [1:0] beat_idx_t;

  typedef enum logic [1:0] {
    IDLE,
    RD_BURST,
    WR_BURST,
    DONE
  } adaptor_state_t;

  // Pick beat idx out of a line; beat 0 is the least significant 64 bits.
  function automatic logic [BEAT_W-1:0] beat_sel(input logic [LINE_W-1:0] line,
                                                 input beat_idx_t         idx);
    return line[idx*BEAT_W +: BEAT_W];
  endfunction

endpackage

// File: rtl/cacheline_burst_adaptor_burst_shift_reg.sv
// Line-wide register with whole-line load and indexed single-beat write.
module burst_shift_reg
  import cache_adaptor_types::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [LINE_W-1:0] i_line,
  input  logic              i_beat_we,
  input  beat_idx_t         i_beat_idx,
  input  logic [BEAT_W-1:0] i_beat_data,
  output logic [LINE_W-1:0] o_line
);

  logic [LINE_W-1:0] r_line;

  // Full-line load wins over a beat write; otherwise only the addressed beat changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_line <= '0;
    end else if (i_load) begin
      r_line <= i_line;
    end else if (i_beat_we) begin
      for (int k = 0; k < BEATS; k++) begin
        if (i_beat_idx == beat_idx_t'(k)) begin
          r_line[k*BEAT_W +: BEAT_W] <= i_beat_data;
        end
      end
    end
  end

  assign o_line = r_line;

endmodule

// File: rtl/cacheline_burst_adaptor.sv
// Turns a 256-bit cache line fill/writeback into a 4-beat 64-bit memory burst.
module cacheline_burst_adaptor
  import cache_adaptor_types::*;
#(
  parameter int unsigned s_line  = 256,
  parameter int unsigned s_burst = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [s_line-1:0]  line_i,
  output logic [s_line-1:0]  line_o,
  input  logic [31:0]        address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  input  logic [s_burst-1:0] burst_i,
  output logic [s_burst-1:0] burst_o,
  output logic [31:0]        address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
);

  localparam int unsigned s_beats = s_line / s_burst;

  adaptor_state_t    r_state, w_state_next;
  beat_idx_t         r_cnt, w_cnt_next;
  logic [31:0]       r_addr;
  logic              w_latch;
  logic              w_wb_load;
  logic              w_fill_we;
  logic              w_last;
  logic [LINE_W-1:0] w_wb_line;

  assign w_last = (r_cnt == beat_idx_t'(s_beats - 1));

  // State and beat counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Line-aligned request address, captured only when a request is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr <= '0;
    end else if (w_latch) begin
      r_addr <= address_i & 32'hFFFF_FFE0;
    end
  end

  // Next-state, counter and memory/cache handshake decode.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_latch      = 1'b0;
    w_wb_load    = 1'b0;
    w_fill_we    = 1'b0;
    read_o       = 1'b0;
    write_o      = 1'b0;
    resp_o       = 1'b0;
    burst_o      = '0;
    case (r_state)
      IDLE: begin
        // Writeback goes first so a dirty victim leaves before the fill.
        if (write_i) begin
          w_latch      = 1'b1;
          w_wb_load    = 1'b1;
          w_state_next = WR_BURST;
        end else if (read_i) begin
          w_latch      = 1'b1;
          w_state_next = RD_BURST;
        end
      end
      RD_BURST: begin
        read_o = 1'b1;
        if (resp_i) begin
          w_fill_we  = 1'b1;
          w_cnt_next = r_cnt + 2'd1;
          if (w_last) w_state_next = DONE;
        end
      end
      WR_BURST: begin
        write_o = 1'b1;
        burst_o = beat_sel(w_wb_line, r_cnt);
        if (resp_i) begin
          w_cnt_next = r_cnt + 2'd1;
          if (w_last) w_state_next = DONE;
        end
      end
      DONE: begin
        resp_o       = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign address_o = r_addr;

  burst_shift_reg u_fill (
    .clk         (clk),
    .rst         (rst),
    .i_load      (1'b0),
    .i_line      ('0),
    .i_beat_we   (w_fill_we),
    .i_beat_idx  (r_cnt),
    .i_beat_data (burst_i),
    .o_line      (line_o)
  );

  burst_shift_reg u_wb (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_wb_load),
    .i_line      (line_i),
    .i_beat_we   (1'b0),
    .i_beat_idx  (r_cnt),
    .i_beat_data ('0),
    .o_line      (w_wb_line)
  );

endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// Directed self-checking bench for cacheline_burst_adaptor.
module tb_cacheline_burst_adaptor;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  int n_chk = 0;
  int n_bad = 0;

  logic [255:0] exp_fill;

  cacheline_burst_adaptor dut (
    .clk       (clk),
    .rst       (rst),
    .line_i    (line_i),
    .line_o    (line_o),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .resp_o    (resp_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_fill(input logic [31:0] addr, input logic [255:0] line, input bit churn);
    read_i    = 1'b1;
    address_i = addr;
    step();
    read_i = 1'b0;
    if (churn) begin
      address_i = ~addr;
      line_i    = {4{64'hDEAD_BEEF_0BAD_F00D}};
      write_i   = 1'b1;
    end
    chk_eq("fill_addr", 256'(address_o), 256'(addr & 32'hFFFF_FFE0));
    chk_eq("fill_read_o", 256'(read_o), 256'(1));
    for (int k = 0; k < 4; k++) begin
      resp_i  = 1'b1;
      burst_i = line[k*64 +: 64];
      step();
      if (k < 3) begin
        chk_eq("fill_mid_read_o", 256'(read_o), 256'(1));
        chk_eq("fill_mid_write_o", 256'(write_o), 256'(0));
        chk_eq("fill_mid_resp_o", 256'(resp_o), 256'(0));
        if (churn) chk_eq("fill_churn_addr", 256'(address_o), 256'(addr & 32'hFFFF_FFE0));
      end
    end
    resp_i  = 1'b0;
    write_i = 1'b0;
    chk_eq("fill_done_resp_o", 256'(resp_o), 256'(1));
    chk_eq("fill_done_read_o", 256'(read_o), 256'(0));
    chk_eq("fill_done_write_o", 256'(write_o), 256'(0));
    chk_eq("fill_line_o", line_o, line);
    step();
    chk_eq("fill_after_resp_o", 256'(resp_o), 256'(0));
    chk_eq("fill_hold_line_o", line_o, line);
    exp_fill = line;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [255:0] line, input int gaps,
                          input bit also_read, input bit churn);
    write_i   = 1'b1;
    read_i    = also_read;
    address_i = addr;
    line_i    = line;
    step();
    write_i = 1'b0;
    read_i  = 1'b0;
    if (churn) begin
      address_i = 32'h5555_5555;
      line_i    = {4{64'hFFFF_0000_FFFF_0000}};
    end
    chk_eq("wr_addr", 256'(address_o), 256'(addr & 32'hFFFF_FFE0));
    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g < gaps; g++) begin
        resp_i = 1'b0;
        chk_eq("wr_gap_burst_o", 256'(burst_o), 256'(line[k*64 +: 64]));
        chk_eq("wr_gap_write_o", 256'(write_o), 256'(1));
        step();
      end
      chk_eq("wr_burst_o", 256'(burst_o), 256'(line[k*64 +: 64]));
      chk_eq("wr_write_o", 256'(write_o), 256'(1));
      chk_eq("wr_read_o", 256'(read_o), 256'(0));
      chk_eq("wr_resp_o_early", 256'(resp_o), 256'(0));
      resp_i = 1'b1;
      step();
    end
    resp_i = 1'b0;
    chk_eq("wr_done_resp_o", 256'(resp_o), 256'(1));
    chk_eq("wr_done_write_o", 256'(write_o), 256'(0));
    chk_eq("wr_done_burst_o", 256'(burst_o), 256'(0));
    chk_eq("wr_line_o_kept", line_o, exp_fill);
    step();
    chk_eq("wr_after_resp_o", 256'(resp_o), 256'(0));
  endtask

  initial begin
    rst       = 1'b1;
    line_i    = '0;
    address_i = '0;
    read_i    = 1'b0;
    write_i   = 1'b0;
    burst_i   = '0;
    resp_i    = 1'b0;
    exp_fill  = '0;
    step();
    step();
    chk_eq("rst_line_o", line_o, 256'(0));
    chk_eq("rst_burst_o", 256'(burst_o), 256'(0));
    chk_eq("rst_address_o", 256'(address_o), 256'(0));
    chk_eq("rst_read_o", 256'(read_o), 256'(0));
    chk_eq("rst_write_o", 256'(write_o), 256'(0));
    chk_eq("rst_resp_o", 256'(resp_o), 256'(0));
    rst = 1'b0;

    // Stray memory strobes while idle must do nothing.
    resp_i  = 1'b1;
    burst_i = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_eq("idle_resp_o", 256'(resp_o), 256'(0));
      chk_eq("idle_read_o", 256'(read_o), 256'(0));
      chk_eq("idle_line_o", line_o, 256'(0));
    end
    resp_i = 1'b0;

    // Zero-wait fill.
    do_fill(32'h0000_1234, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                            64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 1'b0);

    // Writeback with 2-cycle stalls between strobes.
    do_write(32'hABCD_EF1F, {64'hD, 64'hC, 64'hB, 64'hA}, 2, 1'b0, 1'b0);

    // Read and write together: write first, then the re-issued read.
    do_write(32'h0000_0100, {64'h8888_0000_0000_0004, 64'h8888_0000_0000_0003,
                             64'h8888_0000_0000_0002, 64'h8888_0000_0000_0001}, 0, 1'b1, 1'b0);
    do_fill(32'h0000_0100, {64'hA0A0_A0A0_0000_0003, 64'hA0A0_A0A0_0000_0002,
                            64'hA0A0_A0A0_0000_0001, 64'hA0A0_A0A0_0000_0000}, 1'b0);

    // Reset after beat 1 of a fill.
    read_i    = 1'b1;
    address_i = 32'h0000_0800;
    step();
    read_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      resp_i  = 1'b1;
      burst_i = 64'h7777_0000_0000_0000 | 64'(k);
      step();
    end
    resp_i = 1'b0;
    rst    = 1'b1;
    step();
    rst = 1'b0;
    chk_eq("abort_read_o", 256'(read_o), 256'(0));
    chk_eq("abort_line_o", line_o, 256'(0));
    chk_eq("abort_address_o", 256'(address_o), 256'(0));
    chk_eq("abort_resp_o", 256'(resp_o), 256'(0));
    for (int i = 0; i < 3; i++) begin
      step();
      chk_eq("abort_no_resp_o", 256'(resp_o), 256'(0));
    end
    exp_fill = '0;
    do_fill(32'h0000_0820, {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                            64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0}, 1'b0);

    // Inputs churn mid-burst; latched values must hold.
    do_fill(32'h2000_0040, {64'h1, 64'h2, 64'h3, 64'h4}, 1'b1);
    do_write(32'h3000_00E0, {64'h0D0D, 64'h0C0C, 64'h0B0B, 64'h0A0A}, 1, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
